// File: rtl/avm_uart_responder_if.sv
// Avalon-MM slave bus bundle for avm_uart_responder.
interface avm_uart_responder_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avm_uart_responder.sv
// Avalon-MM RX/TX/STATUS polling responder backed by two byte FIFOs.
// Optional macro AVM_RESP_RANDWAIT_EN adds LFSR-jittered wait states.
module avm_uart_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       avm_clk,
  input  logic       rst_w,
  avm_uart_responder_if.slave avm,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] A_RX = 5'd0, A_TX = 5'd4, A_ST = 5'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]  r_cnt, w_cnt_load;
  logic [4:0]  r_addr, w_addr;
  logic        r_rd, r_wr, w_rd, w_req;
  logic        r_wait, w_wait_nxt, w_ack_entry;
  logic [31:0] r_rdata, w_rdata;
  logic        r_pop_rx, r_set_udf, w_pop_nxt, w_udf_nxt;
  logic        r_rx_udf, r_tx_ovf;
  logic [7:0]  w_status;

  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic        w_in_ack, w_rx_push, w_rx_pop, w_tx_pop, w_tx_wr, w_tx_push, w_st_wr;
  logic        w_unused_wd;

  assign w_unused_wd = ^avm.avm_writedata[31:8];
  assign w_req       = avm.avm_read | avm.avm_write;

`ifdef AVM_RESP_RANDWAIT_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge avm_clk or posedge rst_w)
    if (rst_w) r_lfsr <= 8'hA5;
    else if (r_state == S_IDLE && w_req)
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_cnt_load = 4'(WAIT_CYCLES) + {2'b00, r_lfsr[1:0]};
`else
  assign w_cnt_load = 4'(WAIT_CYCLES);
`endif

  // FIFO flags: pointers carry an extra wrap bit
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);

  assign rx_ready = ~w_rx_full;
  assign tx_valid = ~w_tx_empty;
  assign tx_data  = tx_valid ? r_tx_mem[r_tx_rp[AW-1:0]] : 8'h00;

  // State register
  always_ff @(posedge avm_clk or posedge rst_w)
    if (rst_w) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = (w_cnt_load == 4'd0) ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt <= 4'd1) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; with zero wait the access enters ACK straight from IDLE, so decode live inputs there
  always_comb begin
    w_addr      = (r_state == S_IDLE) ? avm.avm_address : r_addr;
    w_rd        = (r_state == S_IDLE) ? avm.avm_read    : r_rd;
    w_wait_nxt  = (w_state_nxt != S_ACK);
    w_ack_entry = (w_state_nxt == S_ACK) && (r_state != S_ACK);
    w_status    = {~w_rx_empty, ~w_tx_full, w_tx_empty, 3'b000, r_tx_ovf, r_rx_udf};
    w_pop_nxt   = w_rd && (w_addr == A_RX) && !w_rx_empty;
    w_udf_nxt   = w_rd && (w_addr == A_RX) &&  w_rx_empty;
    w_rdata     = 32'h0;
    if (w_rd && w_addr == A_RX && !w_rx_empty) w_rdata = {24'h0, r_rx_mem[r_rx_rp[AW-1:0]]};
    else if (w_rd && w_addr == A_ST)           w_rdata = {24'h0, w_status};
  end

  always_ff @(posedge avm_clk or posedge rst_w)
    if (rst_w) begin
      r_cnt <= '0; r_addr <= '0; r_rd <= 1'b0; r_wr <= 1'b0;
      r_wait <= 1'b1; r_rdata <= '0; r_pop_rx <= 1'b0; r_set_udf <= 1'b0;
    end else begin
      r_wait    <= w_wait_nxt;
      r_pop_rx  <= w_ack_entry & w_pop_nxt;
      r_set_udf <= w_ack_entry & w_udf_nxt;
      if (w_ack_entry) r_rdata <= w_rdata;
      if (r_state == S_IDLE && w_req) begin
        r_addr <= avm.avm_address;
        r_rd   <= avm.avm_read;
        r_wr   <= avm.avm_write & ~avm.avm_read;
        r_cnt  <= w_cnt_load;
      end else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
    end

  assign avm.avm_waitrequest = r_wait;
  assign avm.avm_readdata    = r_rdata;

  // Side effects commit at the end of the ACK cycle
  assign w_in_ack  = (r_state == S_ACK);
  assign w_rx_push = rx_valid & rx_ready;
  assign w_rx_pop  = w_in_ack & r_pop_rx;
  assign w_tx_pop  = tx_valid & tx_ready;
  assign w_tx_wr   = w_in_ack & r_wr & (r_addr == A_TX);
  assign w_tx_push = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_st_wr   = w_in_ack & r_wr & (r_addr == A_ST);

  always_ff @(posedge avm_clk or posedge rst_w)
    if (rst_w) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_tx_wp <= '0; r_tx_rp <= '0;
      r_rx_udf <= 1'b0; r_tx_ovf <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      r_rx_udf <= (r_rx_udf & ~(w_st_wr & avm.avm_writedata[0])) | (w_in_ack & r_set_udf);
      r_tx_ovf <= (r_tx_ovf & ~(w_st_wr & avm.avm_writedata[1])) | (w_tx_wr & w_tx_full & ~w_tx_pop);
    end

  always_ff @(posedge avm_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= avm.avm_writedata[7:0];
  end
endmodule

// File: tb/tb_avm_uart_responder.sv
// Directed bench for avm_uart_responder (FIFO_DEPTH=16, WAIT_CYCLES=1).
module tb_avm_uart_responder;
  logic       avm_clk = 1'b0;
  logic       rst_w   = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  int npass = 0;
  int ntot  = 0;

  avm_uart_responder_if u_if ();

  avm_uart_responder #(.FIFO_DEPTH(16), .WAIT_CYCLES(1)) u_dut (
    .avm_clk (avm_clk),
    .rst_w   (rst_w),
    .avm     (u_if),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 avm_clk = ~avm_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One Avalon transfer; returns readdata and the number of edges until waitrequest dropped
  task automatic acc(input logic [4:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, output logic [31:0] rdat, output int lat);
    @(negedge avm_clk);
    u_if.avm_address = a; u_if.avm_read = rd; u_if.avm_write = wr; u_if.avm_writedata = wd;
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge avm_clk); #1;
      lat++;
      if (!u_if.avm_waitrequest) break;
    end
    chk("ack_seen", {31'b0, u_if.avm_waitrequest}, 32'd0);
    rdat = u_if.avm_readdata;
    u_if.avm_read = 1'b0; u_if.avm_write = 1'b0;
    @(posedge avm_clk); #1;
  endtask

  logic [31:0] rd;
  int lat;

  initial begin
    u_if.avm_address = '0; u_if.avm_read = 1'b0; u_if.avm_write = 1'b0; u_if.avm_writedata = '0;

    // 1. reset state
    repeat (2) @(posedge avm_clk);
    #1;
    chk("rst_wait",    {31'b0, u_if.avm_waitrequest}, 32'd1);
    chk("rst_rdata",   u_if.avm_readdata, 32'd0);
    chk("rst_rxready", {31'b0, rx_ready}, 32'd1);
    chk("rst_txvalid", {31'b0, tx_valid}, 32'd0);
    chk("rst_txdata",  {24'b0, tx_data}, 32'd0);
    @(negedge avm_clk); rst_w = 1'b0;

    // 2. latency and empty STATUS
    acc(5'd8, 1, 0, 0, rd, lat);
    chk("lat_status", lat, 32'd2);
    chk("status_empty", rd, 32'h60);
    chk("wait_after_ack", {31'b0, u_if.avm_waitrequest}, 32'd1);
    chk("rdata_hold", u_if.avm_readdata, 32'h60);

    // 3. single RX byte
    @(negedge avm_clk); rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge avm_clk); rx_valid = 1'b0;
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_rx1", rd, 32'hE0);
    acc(5'd0, 1, 0, 0, rd, lat); chk("rx_a5", rd, 32'hA5);
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_rx0", rd, 32'h60);

    // 4. TX fill, overflow, W1C, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) acc(5'd4, 0, 1, i, rd, lat);
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_txfull", rd, 32'h00);
    acc(5'd4, 0, 1, 32'hFF, rd, lat);
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_txovf", rd, 32'h02);
    acc(5'd8, 0, 1, 32'h2, rd, lat);
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_w1c", rd, 32'h00);
    @(negedge avm_clk); tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_valid_drain", {31'b0, tx_valid}, 32'd1);
      chk("tx_data_drain", {24'b0, tx_data}, i);
      @(negedge avm_clk);
    end
    chk("tx_empty_after", {31'b0, tx_valid}, 32'd0);

    // 5. RX underflow
    acc(5'd0, 1, 0, 0, rd, lat); chk("rx_underflow", rd, 32'h0);
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_udf", rd, 32'h61);
    acc(5'd12, 1, 0, 0, rd, lat); chk("rd_other", rd, 32'h0);

    // 6. reset mid-access with 3 bytes in each FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge avm_clk); rx_data = 8'h10 + 8'(i); rx_valid = 1'b1;
    end
    @(negedge avm_clk); rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) acc(5'd4, 0, 1, 32'h30 + i, rd, lat);
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_pre_rst", rd, 32'hC1);
    @(negedge avm_clk);
    u_if.avm_address = 5'd0; u_if.avm_read = 1'b1;
    @(posedge avm_clk); #1;
    chk("in_wait", {31'b0, u_if.avm_waitrequest}, 32'd1);
    rst_w = 1'b1;
    #1;
    chk("midrst_wait",    {31'b0, u_if.avm_waitrequest}, 32'd1);
    chk("midrst_txvalid", {31'b0, tx_valid}, 32'd0);
    chk("midrst_rxready", {31'b0, rx_ready}, 32'd1);
    chk("midrst_rdata",   u_if.avm_readdata, 32'd0);
    @(negedge avm_clk); u_if.avm_read = 1'b0;
    @(negedge avm_clk); rst_w = 1'b0;
    acc(5'd8, 1, 0, 0, rd, lat); chk("status_post_rst", rd, 32'h60);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
